// File: rtl/rv_imem_responder.sv
// rv_imem_responder
//   Answers instruction-fetch requests from a synchronous single-port memory.
//   Holds at most one request in flight, inserts WAIT_STATES wait cycles,
//   and flags requests outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) with o_err.
//
// Ports
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_cyc, i_addr      fetch request valid and byte address
//   o_ack              one-cycle response strobe
//   o_instruction      fetched word (zero unless o_ack)
//   o_err              out-of-range response (only with o_ack)
//   o_busy             request outstanding
//   o_mem_re           memory read enable
//   o_mem_addr         memory word index
//   i_mem_rdata        memory data, valid the cycle after o_mem_re
module rv_imem_responder #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  localparam int         AW          = $clog2(MEM_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cyc,
  input  logic [31:0]   i_addr,
  output logic          o_ack,
  output logic [31:0]   o_instruction,
  output logic          o_err,
  output logic          o_busy,
  output logic          o_mem_re,
  output logic [AW-1:0] o_mem_addr,
  input  logic [31:0]   i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // 33-bit limit so a window touching the top of the address space cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic          err_q;

  logic          in_range;
  logic          accept;
  logic          last_wait;
  logic [AW-1:0] idx;

  assign in_range  = (i_addr >= BASE_ADDR) && ({1'b0, i_addr} < LIMIT);
  // BASE_ADDR is aligned to the window size, so subtracting it never changes
  // the index bits; the word index is taken straight from the address.
  assign idx       = i_addr[AW+1:2];
  assign accept    = i_reset_n && i_cyc && (state_q == S_IDLE || state_q == S_RESP);
  assign last_wait = (state_q == S_WAIT) && (cnt_q == 4'd1);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (i_cyc) begin
            addr_q <= idx;
            err_q  <= !in_range;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_STATES);
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          // i_cyc is ignored here; the pending request always completes.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so an in-flight request is never acknowledged
  // during the reset cycle itself.
  assign o_ack         = i_reset_n && (state_q == S_RESP);
  assign o_err         = o_ack && err_q;
  assign o_instruction = (o_ack && !err_q) ? i_mem_rdata : 32'h0;
  assign o_busy        = i_reset_n && (state_q != S_IDLE);
  // Read is issued the cycle before RESP: the accept cycle with no wait
  // states, otherwise the final wait cycle.
  assign o_mem_re      = i_reset_n && ((WAIT_STATES == 0) ? (accept && in_range)
                                                          : (last_wait && !err_q));
  assign o_mem_addr    = accept ? idx : addr_q;

endmodule

// File: tb/tb_rv_imem_responder.sv
module tb_rv_imem_responder;

  // Four responders: 0 = no wait, base 0; 1 = 3 waits; 2 = base 0x1000;
  // 3 = 2 waits. All are 16 words deep.
  localparam int          NI = 4;
  localparam int          WSA   [NI] = '{0, 3, 0, 2};
  localparam logic [31:0] BASEA [NI] = '{32'h0, 32'h0, 32'h1000, 32'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0]        cyc = '0;
  logic [NI-1:0][31:0]  addr = '0;
  logic [NI-1:0]        ack, err, busy, re;
  logic [NI-1:0][31:0]  instr;
  logic [NI-1:0][3:0]   maddr;
  logic [31:0]          mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] rd;
    always @(posedge clk) if (re[g]) rd <= mem[maddr[g]];
    rv_imem_responder #(
      .MEM_WORDS(16), .BASE_ADDR(BASEA[g]), .WAIT_STATES(WSA[g])
    ) u_dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc[g]), .i_addr(addr[g]),
      .o_ack(ack[g]), .o_instruction(instr[g]), .o_err(err[g]),
      .o_busy(busy[g]), .o_mem_re(re[g]), .o_mem_addr(maddr[g]),
      .i_mem_rdata(rd)
    );
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    cyc = '0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc = '0; cyc[0] = 1'b1; addr[0] = 32'h14;
    repeat (3) begin
      tick(); #1;
      checks++;
      if ({ack, err, busy, re} !== '0 || instr !== '0) begin
        errors++;
        $display("FAIL reset_outputs ack=%b err=%b busy=%b re=%b want all 0", ack, err, busy, re);
      end
    end
    // First cycle with reset released: request accepted immediately.
    tick(); rst_n = 1'b1; #1;
    checks++;
    if (re[0] !== 1'b1 || maddr[0] !== 4'd5) begin
      errors++;
      $display("FAIL first_accept re=%b addr=%0d want re=1 addr=5", re[0], maddr[0]);
    end
    tick(); cyc[0] = 1'b0; #1;
    checks++;
    if (ack[0] !== 1'b1 || err[0] !== 1'b0 || instr[0] !== 32'h0051_0113) begin
      errors++;
      $display("FAIL first_resp ack=%b err=%b instr=%h want 1 0 00510113", ack[0], err[0], instr[0]);
    end
    tick(); #1;
    checks++;
    if (ack[0] !== 1'b0 || busy[0] !== 1'b0 || instr[0] !== 32'h0) begin
      errors++;
      $display("FAIL ack_pulse ack=%b busy=%b instr=%h want 0 0 0", ack[0], busy[0], instr[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 5; i++) begin
      tick();
      cyc[0] = (i < 4); addr[0] = 32'(4 * i);
      #1;
      checks++;
      if (re[0] !== (i < 4) || (i < 4 && maddr[0] !== 4'(i))) begin
        errors++;
        $display("FAIL b2b_re cyc%0d re=%b addr=%0d want re=%b addr=%0d", i, re[0], maddr[0], i < 4, i);
      end
      checks++;
      if (ack[0] !== (i >= 1 && i <= 4) ||
          instr[0] !== ((i >= 1 && i <= 4) ? mem[i-1] : 32'h0)) begin
        errors++;
        $display("FAIL b2b_ack cyc%0d ack=%b instr=%h", i, ack[0], instr[0]);
      end
    end
  endtask

  task automatic test_wait_states();
    tick(); cyc[1] = 1'b1; addr[1] = 32'h8; #1;
    checks++;
    if (re[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL ws3_accept re=%b busy=%b want 0 0", re[1], busy[1]);
    end
    for (int j = 1; j <= 6; j++) begin
      tick(); cyc[1] = 1'b0; #1;
      checks++;
      if (busy[1] !== (j <= 4) || re[1] !== (j == 3) || (j == 3 && maddr[1] !== 4'd2) ||
          ack[1] !== (j == 4) || err[1] !== 1'b0 ||
          instr[1] !== ((j == 4) ? mem[2] : 32'h0)) begin
        errors++;
        $display("FAIL ws3_seq N+%0d busy=%b re=%b addr=%0d ack=%b instr=%h", j, busy[1], re[1], maddr[1], ack[1], instr[1]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] av [3];
    av[0] = 32'h1040; av[1] = 32'h0FFC; av[2] = 32'h103C;
    for (int i = 0; i < 3; i++) begin
      tick(); cyc[2] = 1'b1; addr[2] = av[i]; #1;
      checks++;
      if (re[2] !== (i == 2)) begin
        errors++;
        $display("FAIL oor_re addr=%h re=%b want %b", av[i], re[2], i == 2);
      end
      tick(); cyc[2] = 1'b0; #1;
      checks++;
      if (ack[2] !== 1'b1 || err[2] !== (i != 2) || re[2] !== 1'b0 ||
          instr[2] !== ((i == 2) ? mem[15] : 32'h0)) begin
        errors++;
        $display("FAIL oor_resp addr=%h ack=%b err=%b instr=%h", av[i], ack[2], err[2], instr[2]);
      end
    end
  endtask

  task automatic test_reset_abort();
    tick(); cyc[3] = 1'b1; addr[3] = 32'h8; #1;
    tick(); cyc[3] = 1'b0; rst_n = 1'b0; #1;
    checks++;
    if (ack[3] !== 1'b0 || busy[3] !== 1'b0 || re[3] !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst_cycle ack=%b busy=%b re=%b want 0", ack[3], busy[3], re[3]);
    end
    for (int j = 2; j <= 5; j++) begin
      tick(); rst_n = 1'b1; #1;
      checks++;
      if (ack[3] !== 1'b0 || busy[3] !== 1'b0 || re[3] !== 1'b0) begin
        errors++;
        $display("FAIL abort_after N+%0d ack=%b busy=%b re=%b want 0", j, ack[3], busy[3], re[3]);
      end
    end
  endtask

  task automatic test_misaligned();
    tick(); cyc[0] = 1'b1; addr[0] = 32'h16; #1;
    tick(); cyc[0] = 1'b0; #1;
    checks++;
    if (ack[0] !== 1'b1 || instr[0] !== mem[5]) begin
      errors++;
      $display("FAIL misaligned ack=%b instr=%h want 1 %h", ack[0], instr[0], mem[5]);
    end
  endtask

  // Transaction-level model: a request placed at cycle t is taken when no
  // earlier request is still waiting for its ack, the ack lands at
  // t+1+WS, and the memory read happens at t+WS for in-range addresses.
  task automatic test_random(input int k);
    int          ws, acc_t, idx, nidx, r, ackc;
    bit          pend, inr, ninr, take, e_ack, e_busy, e_re;
    logic [31:0] base, a, e_instr;
    logic [3:0]  e_addr;
    ws = WSA[k]; base = BASEA[k]; pend = 0; acc_t = 0; inr = 0; idx = 0;
    for (int t = 0; t < 250; t++) begin
      tick();
      r = $urandom_range(0, 9);
      if (r < 6)       a = base + $urandom_range(0, 63);
      else if (r < 8)  a = base + 64 + $urandom_range(0, 255);
      else if (r == 8) a = base - 4 - $urandom_range(0, 15);
      else             a = $urandom();
      cyc[k] = ($urandom_range(0, 3) != 0); addr[k] = a;
      #1;
      ninr = (a >= base) && (a - base < 64);
      nidx = int'((a - base) >> 2);
      ackc = acc_t + 1 + ws;
      e_ack   = pend && t == ackc;
      e_busy  = pend && t <= ackc;
      e_instr = (e_ack && inr) ? mem[idx] : 32'h0;
      take    = cyc[k] && !(pend && t < ackc);
      e_re    = 0; e_addr = 'x;
      if (ws > 0 && pend && t == acc_t + ws && inr) begin e_re = 1; e_addr = 4'(idx); end
      if (ws == 0 && take && ninr)                  begin e_re = 1; e_addr = 4'(nidx); end
      checks++;
      if (ack[k] !== e_ack || err[k] !== (e_ack && !inr) || busy[k] !== e_busy ||
          instr[k] !== e_instr) begin
        errors++;
        $display("FAIL rand%0d_resp t=%0d ack=%b err=%b busy=%b instr=%h want %b %b %b %h",
                 k, t, ack[k], err[k], busy[k], instr[k], e_ack, e_ack && !inr, e_busy, e_instr);
      end
      checks++;
      if (re[k] !== e_re || (e_re && maddr[k] !== e_addr)) begin
        errors++;
        $display("FAIL rand%0d_mem t=%0d re=%b addr=%0d want %b %0d", k, t, re[k], maddr[k], e_re, e_addr);
      end
      if (take) begin pend = 1; acc_t = t; inr = ninr; idx = nidx; end
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    mem[5] = 32'h0051_0113;
    test_reset();
    drain();
    test_back_to_back();
    drain();
    test_wait_states();
    drain();
    test_out_of_range();
    drain();
    test_reset_abort();
    drain();
    test_misaligned();
    drain();
    for (int k = 0; k < NI; k++) test_random(k);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
